logic_unit_pipe: RTL

//  Parametrised, pipelined bitwise logic unit for the ULA datapath. Generalises the 8-bit AND

---
 rtl/logic_unit_pipe_pkg.sv | 18 +
 rtl/logic_unit_pipe_if.sv | 27 ++
 rtl/logic_unit_pipe_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 63 ++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Opcode set and shared constants for the pipelined bitwise logic unit.
// Opcode values are shared with the ULA decoder and the test bench.
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle between a producer, the logic unit and its consumer.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  import logic_unit_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_zero
  );

endinterface

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise operation block: res = op(a, b), no width growth.
module logic_unit_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = a;
    case (logic_op_e'(op))
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XNOR:  res = ~(a ^ b);
      OP_NOTA:  res = ~a;
      OP_PASSA: res = a;
      default:  res = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// STAGES-deep stall-capable pipeline around logic_unit_core, with zero flag
// and a tri-state driver onto the shared (WIDTH+1)-bit result bus.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  lu,
  input  logic              bus_en,
  output tri [WIDTH:0]      bus_out
);

  logic [STAGES-1:0] stage_vld;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [WIDTH-1:0]  core_res;
  logic              advance;
  logic              tail_vld;
  logic [WIDTH-1:0]  tail_data;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (lu.in_a),
    .b   (lu.in_b),
    .op  (lu.in_op),
    .res (core_res)
  );

  assign tail_vld  = stage_vld[STAGES-1];
  assign tail_data = stage_data[STAGES-1];

  // Global stall: the whole pipe moves only when the tail is empty or being taken.
  assign advance = !tail_vld || lu.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_data[i] <= '0;
      end
    end else if (advance) begin
      stage_vld[0]  <= lu.in_valid;
      // Bubbles carry zero data so undefined operands never enter the pipe.
      stage_data[0] <= lu.in_valid ? core_res : '0;
      for (int i = 1; i < STAGES; i++) begin
        stage_vld[i]  <= stage_vld[i-1];
        stage_data[i] <= stage_data[i-1];
      end
    end
  end

  assign lu.in_ready  = advance;
  assign lu.out_valid = tail_vld;
  assign lu.out_res   = tail_data;
  assign lu.out_zero  = tail_vld && (tail_data == '0);

  // Carry slot is always 0 for logic ops; release the bus when there is nothing valid.
  assign bus_out = (bus_en && tail_vld) ? {1'b0, tail_data} : {(WIDTH+1){1'bz}};

endmodule
